return_control: RTL and testbench

- Multi-cycle sequencer for RET and RTI. It is the pop-side counterpart of the interrupt/call push sequencer.
- It sits beside the decode stage and drives the stack-pop and PC/flags-restore controls. Fetch/decode are stalled while it runs.
- It emits the same 4-bit step code style as the call sequencer, but walks the steps in reverse order: restore PC low, restore PC high, restore flags (RTI only), done.

---
 rtl/return_control.sv | 132 +++++++++++++
 tb/tb_return_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/return_control.sv
// rtl/return_control.sv - RET/RTI pop sequencer driving stack-pop and PC/flags restore
module return_control #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       retSignal,
    input  logic       rtiSignal,
    output logic [3:0] out,
    output logic       mem_rd,
    output logic       sp_inc,
    output logic       pc_ld_lo,
    output logic       pc_ld_hi,
    output logic       flags_ld,
    output logic       stall,
    output logic       done
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("return_control: MEM_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP_L = 3'd1,
        S_POP_H = 3'd2,
        S_POP_F = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    localparam logic [3:0] CODE_IDLE  = 4'b0000;
    localparam logic [3:0] CODE_POP_L = 4'b0001;
    localparam logic [3:0] CODE_POP_H = 4'b0011;
    localparam logic [3:0] CODE_POP_F = 4'b0111;
    localparam logic [3:0] CODE_DONE  = 4'b1000;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       is_rti;
    logic       is_rti_nxt;
    logic       in_pop_nxt;
    logic       final_nxt;

    // Next-state logic: requests only matter in IDLE, each pop lasts MEM_LAT cycles
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        is_rti_nxt = is_rti;
        case (state)
            S_IDLE: begin
                if (rtiSignal) begin
                    is_rti_nxt = 1'b1;
                    cnt_nxt    = 4'd0;
                    state_nxt  = S_POP_L;
                end else if (retSignal) begin
                    is_rti_nxt = 1'b0;
                    cnt_nxt    = 4'd0;
                    state_nxt  = S_POP_L;
                end
            end
            S_POP_L, S_POP_H, S_POP_F: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = 4'd0;
                    if (state == S_POP_L) begin
                        state_nxt = S_POP_H;
                    end else if (state == S_POP_H) begin
                        state_nxt = is_rti ? S_POP_F : S_DONE;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Decode of the upcoming state/counter, so registered outputs line up with the state they describe
    always_comb begin
        in_pop_nxt = (state_nxt == S_POP_L) || (state_nxt == S_POP_H) || (state_nxt == S_POP_F);
        final_nxt  = in_pop_nxt && (cnt_nxt == LAST_CNT);
    end

    // State, counter, RTI flag and registered Moore outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            is_rti   <= 1'b0;
            out      <= CODE_IDLE;
            mem_rd   <= 1'b0;
            sp_inc   <= 1'b0;
            pc_ld_lo <= 1'b0;
            pc_ld_hi <= 1'b0;
            flags_ld <= 1'b0;
            stall    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            is_rti   <= is_rti_nxt;
            case (state_nxt)
                S_POP_L: out <= CODE_POP_L;
                S_POP_H: out <= CODE_POP_H;
                S_POP_F: out <= CODE_POP_F;
                S_DONE:  out <= CODE_DONE;
                default: out <= CODE_IDLE;
            endcase
            mem_rd   <= in_pop_nxt;
            sp_inc   <= final_nxt;
            pc_ld_lo <= final_nxt && (state_nxt == S_POP_L);
            pc_ld_hi <= final_nxt && (state_nxt == S_POP_H);
            flags_ld <= final_nxt && (state_nxt == S_POP_F);
            stall    <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_return_control.sv
// tb/tb_return_control.sv - self-checking bench for return_control at MEM_LAT 1 and 3
module tb_return_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ret1 = 1'b0, rti1 = 1'b0, ret3 = 1'b0, rti3 = 1'b0;

    logic [3:0] out1, out3;
    logic mem_rd1, sp_inc1, lo1, hi1, fl1, stall1, done1;
    logic mem_rd3, sp_inc3, lo3, hi3, fl3, stall3, done3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    return_control #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .retSignal(ret1), .rtiSignal(rti1),
        .out(out1), .mem_rd(mem_rd1), .sp_inc(sp_inc1), .pc_ld_lo(lo1),
        .pc_ld_hi(hi1), .flags_ld(fl1), .stall(stall1), .done(done1)
    );

    return_control #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .retSignal(ret3), .rtiSignal(rti3),
        .out(out3), .mem_rd(mem_rd3), .sp_inc(sp_inc3), .pc_ld_lo(lo3),
        .pc_ld_hi(hi3), .flags_ld(fl3), .stall(stall3), .done(done3)
    );

    // Expected output vector {code, mem_rd, sp_inc, lo, hi, flags, stall, done} for cycle k of a sequence
    function automatic logic [10:0] exp_vec(input bit rti, input int lat, input int k);
        int npop;
        int p;
        bit fin;
        logic [3:0] code;
        npop = rti ? 3 : 2;
        if (k < npop * lat) begin
            p    = k / lat;
            fin  = ((k % lat) == lat - 1);
            code = (p == 0) ? 4'b0001 : ((p == 1) ? 4'b0011 : 4'b0111);
            return {code, 1'b1, fin, fin && (p == 0), fin && (p == 1), fin && (p == 2), 1'b1, 1'b0};
        end
        return {4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    endfunction

    bit busy1 = 0, kind1 = 0, busy3 = 0, kind3 = 0;
    int k1 = 0, k3 = 0;

    // Reference model: a sequence is a count of cycles since acceptance; requests only accepted when not busy
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy1 <= 0; k1 <= 0; busy3 <= 0; k3 <= 0;
        end else begin
            if (!busy1) begin
                if (ret1 || rti1) begin busy1 <= 1; kind1 <= rti1; k1 <= 0; end
            end else begin
                if (k1 == (kind1 ? 3 : 2) * 1) busy1 <= 0;
                k1 <= k1 + 1;
            end
            if (!busy3) begin
                if (ret3 || rti3) begin busy3 <= 1; kind3 <= rti3; k3 <= 0; end
            end else begin
                if (k3 == (kind3 ? 3 : 2) * 3) busy3 <= 0;
                k3 <= k3 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare both DUTs against the model on the falling edge
    task automatic tick();
        logic [10:0] e1, e3;
        @(negedge clk);
        e1 = busy1 ? exp_vec(kind1, 1, k1) : 11'd0;
        e3 = busy3 ? exp_vec(kind3, 3, k3) : 11'd0;
        chk("dut1_model", 32'({out1, mem_rd1, sp_inc1, lo1, hi1, fl1, stall1, done1}), 32'(e1));
        chk("dut3_model", 32'({out3, mem_rd3, sp_inc3, lo3, hi3, fl3, stall3, done3}), 32'(e3));
    endtask

    logic [3:0]  codes [0:15];
    logic [15:0] m_rd, m_sp, m_lo, m_hi, m_fl, m_st, m_dn;

    // Run ncyc cycles after a request was set up; bit i of each mask is cycle i+1
    task automatic capture(input bit use3, input int ncyc, input int inject_at);
        m_rd = 0; m_sp = 0; m_lo = 0; m_hi = 0; m_fl = 0; m_st = 0; m_dn = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            ret1 = 0; rti1 = 0; ret3 = 0; rti3 = 0;
            if (c == inject_at) begin
                if (use3) ret3 = 1; else ret1 = 1;
            end
            codes[c-1] = use3 ? out3 : out1;
            m_rd[c-1]  = use3 ? mem_rd3 : mem_rd1;
            m_sp[c-1]  = use3 ? sp_inc3 : sp_inc1;
            m_lo[c-1]  = use3 ? lo3 : lo1;
            m_hi[c-1]  = use3 ? hi3 : hi1;
            m_fl[c-1]  = use3 ? fl3 : fl1;
            m_st[c-1]  = use3 ? stall3 : stall1;
            m_dn[c-1]  = use3 ? done3 : done1;
        end
    endtask

    logic fl_seen;

    initial begin
        // Reset hold with a toggling request
        for (int i = 0; i < 6; i++) begin
            tick();
            ret1 = ~ret1;
            ret3 = ~ret3;
            chk("rst_hold_out", 32'(out1), 32'd0);
            chk("rst_hold_strobes", 32'({sp_inc1, lo1, hi1, fl1, stall1, done1, mem_rd3, stall3}), 32'd0);
        end
        ret1 = 0; ret3 = 0;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'({out1, stall1, out3, stall3}), 32'd0);
        end

        // RET at MEM_LAT=1
        ret1 = 1;
        capture(0, 4, 0);
        chk("ret_code_c1", 32'(codes[0]), 32'h1);
        chk("ret_code_c2", 32'(codes[1]), 32'h3);
        chk("ret_code_c3", 32'(codes[2]), 32'h8);
        chk("ret_code_c4", 32'(codes[3]), 32'h0);
        chk("ret_lo", 32'(m_lo), 32'b0001);
        chk("ret_hi", 32'(m_hi), 32'b0010);
        chk("ret_sp", 32'(m_sp), 32'b0011);
        chk("ret_flags", 32'(m_fl), 32'b0000);
        chk("ret_done", 32'(m_dn), 32'b0100);
        chk("ret_stall", 32'(m_st), 32'b0111);

        // RTI at MEM_LAT=1
        rti1 = 1;
        capture(0, 5, 0);
        chk("rti_code_c3", 32'(codes[2]), 32'h7);
        chk("rti_code_c4", 32'(codes[3]), 32'h8);
        chk("rti_code_c5", 32'(codes[4]), 32'h0);
        chk("rti_flags", 32'(m_fl), 32'b00100);
        chk("rti_sp", 32'(m_sp), 32'b00111);
        chk("rti_stall", 32'(m_st), 32'b01111);

        // RTI at MEM_LAT=3
        rti3 = 1;
        capture(1, 12, 0);
        chk("rti3_mem_rd", 32'(m_rd), 32'h1FF);
        chk("rti3_loads", 32'(m_lo | m_hi | m_fl), 32'b0001_0010_0100);
        chk("rti3_sp", 32'(m_sp), 32'b0001_0010_0100);
        chk("rti3_done", 32'(m_dn), 32'h200);
        chk("rti3_stall", 32'(m_st), 32'h3FF);

        // RET at MEM_LAT=3: 7 busy cycles
        ret3 = 1;
        capture(1, 9, 0);
        chk("ret3_stall", 32'(m_st), 32'h07F);
        chk("ret3_flags", 32'(m_fl), 32'h0);

        // Both requests together behave as RTI
        ret1 = 1; rti1 = 1;
        capture(0, 5, 0);
        chk("both_flags", 32'(m_fl), 32'b00100);
        chk("both_stall", 32'(m_st), 32'b01111);

        // RET pulse during POP_H is ignored
        ret1 = 1;
        capture(0, 6, 2);
        chk("ignored_stall", 32'(m_st), 32'b000111);
        chk("ignored_done", 32'(m_dn), 32'b000100);

        // Async reset in the middle of POP_H of an RTI
        rti3 = 1;
        capture(1, 5, 0);
        chk("pre_rst_in_pop_h", 32'(out3), 32'h3);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async_rst_out", 32'(out3), 32'h0);
        chk("async_rst_stall", 32'(stall3), 32'h0);
        tick();
        tick();
        rst = 1;
        fl_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            fl_seen = fl_seen | fl3;
        end
        chk("post_rst_no_flags", 32'(fl_seen), 32'h0);
        chk("post_rst_idle3", 32'({out3, stall3}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
